ifu_prefetch: RTL and testbench

Parametrised instruction fetch unit replacing the fixed PC/IR/PC-mux fetch slice of the datapath. It owns the fetch PC, issues sequential requests to instruction memory over a valid/ready handshake with variable latency, buffers in-order responses in a prefetch FIFO, and hands {instruction, PC} pairs to decode over valid/ready. It also accepts redirects (branch/jump targets) that flush buffered and in-flight instructions.

---
 rtl/ifu_prefetch_if.sv | 37 +++
 rtl/ifu_prefetch.sv | 96 +++++++++
 tb/tb_ifu_prefetch.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/ifu_prefetch_if.sv
// Fetch-unit bus bundle: memory request/response, redirect and decode-side
// handshake. The fetch unit connects as master; memory and decode together
// form the slave side.
interface ifu_prefetch_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                  ifu_prefetch_req_valid_out;
  logic [ADDR_WIDTH-1:0] ifu_prefetch_req_addr_out;
  logic                  ifu_prefetch_req_ready_in;
  logic                  ifu_prefetch_resp_valid_in;
  logic [DATA_WIDTH-1:0] ifu_prefetch_resp_data_in;
  logic                  ifu_prefetch_redirect_valid_in;
  logic [ADDR_WIDTH-1:0] ifu_prefetch_redirect_addr_in;
  logic                  ifu_prefetch_out_valid_out;
  logic [DATA_WIDTH-1:0] ifu_prefetch_out_instr_out;
  logic [ADDR_WIDTH-1:0] ifu_prefetch_out_pc_out;
  logic                  ifu_prefetch_out_ready_in;

  modport master (
    output ifu_prefetch_req_valid_out, ifu_prefetch_req_addr_out,
    input  ifu_prefetch_req_ready_in,
    input  ifu_prefetch_resp_valid_in, ifu_prefetch_resp_data_in,
    input  ifu_prefetch_redirect_valid_in, ifu_prefetch_redirect_addr_in,
    output ifu_prefetch_out_valid_out, ifu_prefetch_out_instr_out, ifu_prefetch_out_pc_out,
    input  ifu_prefetch_out_ready_in
  );

  modport slave (
    input  ifu_prefetch_req_valid_out, ifu_prefetch_req_addr_out,
    output ifu_prefetch_req_ready_in,
    output ifu_prefetch_resp_valid_in, ifu_prefetch_resp_data_in,
    output ifu_prefetch_redirect_valid_in, ifu_prefetch_redirect_addr_in,
    input  ifu_prefetch_out_valid_out, ifu_prefetch_out_instr_out, ifu_prefetch_out_pc_out,
    output ifu_prefetch_out_ready_in
  );
endinterface

// File: rtl/ifu_prefetch.sv
// Instruction fetch unit: owns the fetch PC, issues credit-limited sequential
// requests, buffers in-order responses in a prefetch FIFO and hands {instr, pc}
// to decode. Redirects flush the FIFO and drop responses still in flight.
// Optional: define IFU_PREFETCH_BYPASS_EN for a zero-cycle path from a
// response into an empty FIFO straight to decode.
module ifu_prefetch #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    FIFO_DEPTH = 4,
  parameter int                    PC_STEP    = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_ADDR = '0
) (
  input  logic           ifu_prefetch_clock_in,
  input  logic           ifu_prefetch_reset_in,
  ifu_prefetch_if.master bus
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] STEP  = ADDR_WIDTH'(PC_STEP);
  localparam logic [ADDR_WIDTH-1:0] ALIGN = ~(ADDR_WIDTH'(PC_STEP - 1));

  logic [ADDR_WIDTH-1:0]                 fetch_pc_q, resp_pc_q;
  logic [FIFO_DEPTH-1:0][ADDR_WIDTH-1:0] pc_mem_q;
  logic [FIFO_DEPTH-1:0][DATA_WIDTH-1:0] instr_mem_q;
  logic [PW-1:0]                         rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]                         cnt_q, outs_q, disc_q;

  logic          redir, hs, rsp, keep, push, pop, byp_take, not_empty, out_vld;
  logic [CW:0]   used;
  logic [CW-1:0] outs_d;

  assign redir     = bus.ifu_prefetch_redirect_valid_in;
  assign rsp       = bus.ifu_prefetch_resp_valid_in;
  assign not_empty = (cnt_q != '0);
  // Credit counts buffered plus in-flight words so every response has a slot.
  assign used      = {1'b0, cnt_q} + {1'b0, outs_q};

  assign bus.ifu_prefetch_req_valid_out = ifu_prefetch_reset_in && (used < (CW+1)'(FIFO_DEPTH));
  assign bus.ifu_prefetch_req_addr_out  = fetch_pc_q;
  assign hs     = bus.ifu_prefetch_req_valid_out & bus.ifu_prefetch_req_ready_in;
  assign keep   = rsp & (disc_q == '0);
  assign outs_d = outs_q + CW'(hs) - CW'(rsp);

`ifdef IFU_PREFETCH_BYPASS_EN
  logic byp;
  assign byp      = keep & ~not_empty;
  assign out_vld  = ~redir & (not_empty | byp);
  assign byp_take = byp & ~redir & bus.ifu_prefetch_out_ready_in;
  assign bus.ifu_prefetch_out_instr_out = not_empty ? instr_mem_q[rd_ptr_q] : bus.ifu_prefetch_resp_data_in;
  assign bus.ifu_prefetch_out_pc_out    = not_empty ? pc_mem_q[rd_ptr_q]    : resp_pc_q;
`else
  assign out_vld  = ~redir & not_empty;
  assign byp_take = 1'b0;
  assign bus.ifu_prefetch_out_instr_out = instr_mem_q[rd_ptr_q];
  assign bus.ifu_prefetch_out_pc_out    = pc_mem_q[rd_ptr_q];
`endif

  assign bus.ifu_prefetch_out_valid_out = out_vld;
  assign push = keep & ~redir & ~byp_take;
  assign pop  = out_vld & bus.ifu_prefetch_out_ready_in & not_empty;

  // PCs, counters and FIFO storage; redirect overrides push/pop/increment.
  always_ff @(posedge ifu_prefetch_clock_in or negedge ifu_prefetch_reset_in) begin
    if (!ifu_prefetch_reset_in) begin
      fetch_pc_q  <= RESET_ADDR;
      resp_pc_q   <= RESET_ADDR;
      pc_mem_q    <= {FIFO_DEPTH{RESET_ADDR}};
      instr_mem_q <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      cnt_q       <= '0;
      outs_q      <= '0;
      disc_q      <= '0;
    end else begin
      outs_q <= outs_d;
      if (redir) begin
        fetch_pc_q <= bus.ifu_prefetch_redirect_addr_in & ALIGN;
        resp_pc_q  <= bus.ifu_prefetch_redirect_addr_in & ALIGN;
        rd_ptr_q   <= wr_ptr_q;
        cnt_q      <= '0;
        disc_q     <= outs_d;
      end else begin
        if (hs) fetch_pc_q <= fetch_pc_q + STEP;
        if (rsp && !keep) disc_q <= disc_q - 1'b1;
        if (keep) resp_pc_q <= resp_pc_q + STEP;
        if (push) begin
          pc_mem_q[wr_ptr_q]    <= resp_pc_q;
          instr_mem_q[wr_ptr_q] <= bus.ifu_prefetch_resp_data_in;
          wr_ptr_q              <= wr_ptr_q + 1'b1;
        end
        if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
        cnt_q <= cnt_q + CW'(push) - CW'(pop);
      end
    end
  end
endmodule

// File: tb/tb_ifu_prefetch.sv
// Bench for ifu_prefetch: variable-latency memory, queue-based reference
// model of the fetch unit, per-cycle output comparison, plus directed
// scenarios with literal expectations.
module tb_ifu_prefetch;
  localparam int DEPTH = 4;
  logic gclk = 1'b0;
  logic grst_n = 1'b0;
  int   pass_cnt = 0, total_cnt = 0;

  always #5 gclk = ~gclk;

  ifu_prefetch_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bif();
  ifu_prefetch #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .FIFO_DEPTH(DEPTH), .PC_STEP(4),
                 .RESET_ADDR(32'h0)) dut (
    .ifu_prefetch_clock_in(gclk),
    .ifu_prefetch_reset_in(grst_n),
    .bus(bif.master)
  );

  // reference model state
  logic [31:0] m_fpc, m_rpc;
  logic [31:0] m_pcq[$], m_insq[$];
  int          m_outs, m_disc;
  // memory environment
  logic [31:0] mq_addr[$];
  int          mq_rdy[$];
  int          cyc = 0;
  bit          mem_hold = 0;
  bit          watch = 0;
  logic [31:0] watch_pc;

  function automatic logic [31:0] word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  task automatic model_reset();
    m_fpc = 0; m_rpc = 0; m_outs = 0; m_disc = 0;
    m_pcq.delete(); m_insq.delete(); mq_addr.delete(); mq_rdy.delete();
  endtask

  // One clock cycle: drive inputs, compare outputs with the model, advance model.
  task automatic step(input bit rr, input bit orr, input bit rd, input logic [31:0] ra, input int latmax);
    bit e_rv, e_ov, hs, rsp;
    logic [31:0] rdata, al;
    @(negedge gclk);
    rsp   = !mem_hold && mq_addr.size() > 0 && mq_rdy[0] <= cyc;
    rdata = rsp ? word(mq_addr[0]) : $urandom;
    bif.ifu_prefetch_req_ready_in      = rr;
    bif.ifu_prefetch_out_ready_in      = orr;
    bif.ifu_prefetch_redirect_valid_in = rd;
    bif.ifu_prefetch_redirect_addr_in  = ra;
    bif.ifu_prefetch_resp_valid_in     = rsp;
    bif.ifu_prefetch_resp_data_in      = rdata;
    #1;
    e_rv = (m_pcq.size() + m_outs) < DEPTH;
    e_ov = (m_pcq.size() > 0) && !rd;
    chk("req_valid", bif.ifu_prefetch_req_valid_out, e_rv);
    chk("req_addr", bif.ifu_prefetch_req_addr_out, m_fpc);
    chk("out_valid", bif.ifu_prefetch_out_valid_out, e_ov);
    if (e_ov) begin
      chk("out_pc", bif.ifu_prefetch_out_pc_out, m_pcq[0]);
      chk("out_instr", bif.ifu_prefetch_out_instr_out, m_insq[0]);
      chk("instr_matches_pc", bif.ifu_prefetch_out_instr_out, word(bif.ifu_prefetch_out_pc_out));
    end
    if (watch && bif.ifu_prefetch_out_valid_out && !rd) begin
      chk("first_pc_after_redirect", bif.ifu_prefetch_out_pc_out, watch_pc);
      watch = 0;
    end
    hs = e_rv && rr;
    if (hs) begin
      mq_addr.push_back(m_fpc);
      mq_rdy.push_back(cyc + 1 + $urandom_range(0, latmax));
    end
    if (rsp) begin
      void'(mq_addr.pop_front());
      void'(mq_rdy.pop_front());
    end
    if (rd) begin
      al = ra & ~32'h3;
      m_pcq.delete(); m_insq.delete();
      m_fpc = al; m_rpc = al;
      m_disc = m_outs + int'(hs) - int'(rsp);
    end else begin
      if (hs) m_fpc = m_fpc + 4;
      if (e_ov && orr) begin
        void'(m_pcq.pop_front());
        void'(m_insq.pop_front());
      end
      if (rsp) begin
        if (m_disc > 0) m_disc--;
        else begin
          m_pcq.push_back(m_rpc);
          m_insq.push_back(rdata);
          m_rpc = m_rpc + 4;
        end
      end
    end
    m_outs = m_outs + int'(hs) - int'(rsp);
    @(posedge gclk);
    cyc++;
  endtask

  initial begin
    bif.ifu_prefetch_req_ready_in      = 0;
    bif.ifu_prefetch_out_ready_in      = 0;
    bif.ifu_prefetch_redirect_valid_in = 0;
    bif.ifu_prefetch_redirect_addr_in  = 0;
    bif.ifu_prefetch_resp_valid_in     = 0;
    bif.ifu_prefetch_resp_data_in      = 0;
    model_reset();
    #3;
    chk("rst_req_valid", bif.ifu_prefetch_req_valid_out, 1'b0);
    chk("rst_req_addr", bif.ifu_prefetch_req_addr_out, 32'h0);
    chk("rst_out_valid", bif.ifu_prefetch_out_valid_out, 1'b0);
    chk("rst_out_instr", bif.ifu_prefetch_out_instr_out, 32'h0);
    chk("rst_out_pc", bif.ifu_prefetch_out_pc_out, 32'h0);
    @(posedge gclk); #2 grst_n = 1;

    // fill with decode stalled: exactly DEPTH requests, then credit exhausted
    repeat (8) step(1, 0, 0, 0, 0);
    #2;
    chk("fill_req_valid", bif.ifu_prefetch_req_valid_out, 1'b0);
    chk("fill_req_addr", bif.ifu_prefetch_req_addr_out, 32'h10);
    chk("fill_head_pc", bif.ifu_prefetch_out_pc_out, 32'h0);
    chk("fill_out_valid", bif.ifu_prefetch_out_valid_out, 1'b1);
    // drain and stream back-to-back
    repeat (12) step(1, 1, 0, 0, 0);

    // three outstanding, then redirect to an unaligned target
    repeat (8) step(0, 1, 0, 0, 0);
    mem_hold = 1;
    repeat (3) step(1, 1, 0, 0, 0);
    step(0, 1, 1, 32'h103, 0);
    #2;
    chk("redir_req_addr", bif.ifu_prefetch_req_addr_out, 32'h100);
    watch = 1; watch_pc = 32'h100;
    mem_hold = 0;
    repeat (12) step(1, 1, 0, 0, 0);
    chk("redir_first_seen", watch, 1'b0);

    // PC wrap at the top of the address space
    repeat (8) step(0, 1, 0, 0, 0);
    step(0, 1, 1, 32'hFFFF_FFFE, 0);
    watch = 1; watch_pc = 32'hFFFF_FFFC;
    step(1, 1, 0, 0, 0);
    #2;
    chk("wrap_req_addr", bif.ifu_prefetch_req_addr_out, 32'h0);
    repeat (8) step(1, 1, 0, 0, 0);
    chk("wrap_first_seen", watch, 1'b0);

    // randomized traffic with redirects and variable latency
    for (int i = 0; i < 800; i++)
      step(($urandom % 4) != 0, ($urandom % 4) != 0, ($urandom % 20) == 0, $urandom, 3);

    // reset mid-burst with two entries buffered
    repeat (10) step(0, 1, 0, 0, 0);
    grst_n = 0; #2 model_reset(); cyc = 0;
    @(posedge gclk); #2 grst_n = 1;
    repeat (3) step(1, 0, 0, 0, 0);
    #2;
    chk("burst_out_valid", bif.ifu_prefetch_out_valid_out, 1'b1);
    grst_n = 0;
    #1;
    chk("async_rst_out_valid", bif.ifu_prefetch_out_valid_out, 1'b0);
    chk("async_rst_req_valid", bif.ifu_prefetch_req_valid_out, 1'b0);
    chk("async_rst_req_addr", bif.ifu_prefetch_req_addr_out, 32'h0);
    bif.ifu_prefetch_resp_valid_in = 0;
    model_reset(); cyc = 0;
    @(posedge gclk); @(posedge gclk); #2 grst_n = 1;
    #1;
    chk("restart_req_valid", bif.ifu_prefetch_req_valid_out, 1'b1);
    chk("restart_req_addr", bif.ifu_prefetch_req_addr_out, 32'h0);
    repeat (10) step(1, 1, 0, 0, 1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
